// File: rtl/bsg_axil_pkg.sv
// Shared AXI-lite definitions: serializer FSM states and response encodings.
package bsg_axil_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_rd_addr,
    e_rd_data,
    e_wr_req,
    e_wr_resp
  } axil_rw_state_e;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

endpackage

// File: rtl/bsg_axil_rw_serializer_if.sv
// AXI-lite port bundle; master drives addr/data/ready-for-responses, slave the rest.
interface bsg_axil_rw_serializer_if
  #(parameter int unsigned addr_width_p = 32
  , parameter int unsigned data_width_p = 32
  );

  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;

  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master
    (output awaddr, awprot, awvalid, input awready
    ,output wdata, wstrb, wvalid, input wready
    ,input bresp, bvalid, output bready
    ,output araddr, arprot, arvalid, input arready
    ,input rdata, rresp, rvalid, output rready
    );

  modport slave
    (input awaddr, awprot, awvalid, output awready
    ,input wdata, wstrb, wvalid, output wready
    ,output bresp, bvalid, input bready
    ,input araddr, arprot, arvalid, output arready
    ,output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/bsg_dff_reset.sv
// Register with synchronous active-high reset to a parameterised value.
module bsg_dff_reset
  #(parameter int unsigned            width_p     = 1
  , parameter logic [width_p-1:0]     reset_val_p = '0
  )
  (input  logic               clk_i
  ,input  logic               reset_i
  ,input  logic [width_p-1:0] data_i
  ,output logic [width_p-1:0] data_o
  );

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      data_q <= reset_val_p;
    else
      data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_axil_rw_serializer.sv
// Serialises an AXI-lite slave port onto a master port with at most one
// transaction in flight and reads/writes granted alternately under contention.
module bsg_axil_rw_serializer
  import bsg_axil_pkg::*;
  #(parameter int unsigned addr_width_p = 32
  , parameter int unsigned data_width_p = 32
  )
  (input  logic                     clk_i
  ,input  logic                     reset_n_i
  ,bsg_axil_rw_serializer_if.slave  s00_axil
  ,bsg_axil_rw_serializer_if.master m00_axil
  );

  axil_rw_state_e state_q, state_d;
  logic [$bits(axil_rw_state_e)-1:0] state_raw;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic last_wr_q, last_wr_d;
  logic aw_hs, w_hs;

  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;

  bsg_dff_reset
    #(.width_p($bits(axil_rw_state_e)), .reset_val_p(e_idle))
    state_reg
     (.clk_i(clk_i), .reset_i(~reset_n_i), .data_i(state_d), .data_o(state_raw));

  assign state_q = axil_rw_state_e'(state_raw);

  bsg_dff_reset
    #(.width_p(2), .reset_val_p(2'b00))
    done_reg
     (.clk_i(clk_i), .reset_i(~reset_n_i)
     ,.data_i({aw_done_d, w_done_d}), .data_o({aw_done_q, w_done_q}));

  // Resets to "last was write" so the first contention goes to the read.
  bsg_dff_reset
    #(.width_p(1), .reset_val_p(1'b1))
    last_wr_reg
     (.clk_i(clk_i), .reset_i(~reset_n_i), .data_i(last_wr_d), .data_o(last_wr_q));

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    last_wr_d = last_wr_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;

    unique case (state_q)
      e_idle: begin
        if (s00_axil.arvalid && (!s00_axil.awvalid || last_wr_q)) begin
          state_d   = e_rd_addr;
          last_wr_d = 1'b0;
        end else if (s00_axil.awvalid) begin
          state_d   = e_wr_req;
          last_wr_d = 1'b1;
        end
      end

      e_rd_addr: begin
        m_arvalid = s00_axil.arvalid;
        s_arready = m00_axil.arready;
        if (s00_axil.arvalid && m00_axil.arready)
          state_d = e_rd_data;
      end

      e_rd_data: begin
        m_rready = s00_axil.rready;
        s_rvalid = m00_axil.rvalid;
        if (m00_axil.rvalid && s00_axil.rready)
          state_d = e_idle;
      end

      e_wr_req: begin
        m_awvalid = s00_axil.awvalid & ~aw_done_q;
        s_awready = m00_axil.awready & ~aw_done_q;
        m_wvalid  = s00_axil.wvalid & ~w_done_q;
        s_wready  = m00_axil.wready & ~w_done_q;
        aw_hs     = s00_axil.awvalid & m00_axil.awready & ~aw_done_q;
        w_hs      = s00_axil.wvalid & m00_axil.wready & ~w_done_q;
        // Completion counts a flag already set or a handshake this cycle.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = e_wr_resp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end

      e_wr_resp: begin
        m_bready = s00_axil.bready;
        s_bvalid = m00_axil.bvalid;
        if (m00_axil.bvalid && s00_axil.bready)
          state_d = e_idle;
      end

      default: state_d = e_idle;
    endcase
  end

  assign m00_axil.awaddr = s00_axil.awaddr;
  assign m00_axil.awprot = s00_axil.awprot;
  assign m00_axil.wdata  = s00_axil.wdata;
  assign m00_axil.wstrb  = s00_axil.wstrb;
  assign m00_axil.araddr = s00_axil.araddr;
  assign m00_axil.arprot = s00_axil.arprot;
  assign s00_axil.bresp  = m00_axil.bresp;
  assign s00_axil.rdata  = m00_axil.rdata;
  assign s00_axil.rresp  = m00_axil.rresp;

  // Handshakes are forced low while reset is held, whatever the stale state.
  assign m00_axil.awvalid = reset_n_i & m_awvalid;
  assign m00_axil.wvalid  = reset_n_i & m_wvalid;
  assign m00_axil.bready  = reset_n_i & m_bready;
  assign m00_axil.arvalid = reset_n_i & m_arvalid;
  assign m00_axil.rready  = reset_n_i & m_rready;
  assign s00_axil.awready = reset_n_i & s_awready;
  assign s00_axil.wready  = reset_n_i & s_wready;
  assign s00_axil.bvalid  = reset_n_i & s_bvalid;
  assign s00_axil.arready = reset_n_i & s_arready;
  assign s00_axil.rvalid  = reset_n_i & s_rvalid;

`ifndef SYNTHESIS
  a_ar_aw_mutex: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(m00_axil.arvalid && m00_axil.awvalid));

  a_s_ar_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (s00_axil.arvalid && !s00_axil.arready) |=> s00_axil.arvalid);

  a_s_aw_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (s00_axil.awvalid && !s00_axil.awready) |=> s00_axil.awvalid);

  a_s_w_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (s00_axil.wvalid && !s00_axil.wready) |=> s00_axil.wvalid);
`endif

endmodule

// File: tb/tb_bsg_axil_rw_serializer.sv
// Directed cycle-by-cycle vectors for bsg_axil_rw_serializer handshake gating.
module tb_bsg_axil_rw_serializer;
  import bsg_axil_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic reset_n;

  bsg_axil_rw_serializer_if #(.addr_width_p(AW), .data_width_p(DW)) s_if ();
  bsg_axil_rw_serializer_if #(.addr_width_p(AW), .data_width_p(DW)) m_if ();

  bsg_axil_rw_serializer #(.addr_width_p(AW), .data_width_p(DW)) dut
    (.clk_i(clk), .reset_n_i(reset_n), .s00_axil(s_if.slave), .m00_axil(m_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in : {s.arvalid, s.awvalid, s.wvalid, s.rready, s.bready,
  //       m.arready, m.awready, m.wready, m.rvalid, m.bvalid}
  // exp: {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready,
  //       s.arready, s.awready, s.wready, s.rvalid, s.bvalid}
  typedef struct {
    logic       rst_n;
    logic [9:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst_n, input logic [9:0] in, input logic [9:0] exp);
    vec_t v;
    v.rst_n = rst_n;
    v.in    = in;
    v.exp   = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst_n, input logic [9:0] in);
    reset_n        = rst_n;
    s_if.arvalid   = in[9];
    s_if.awvalid   = in[8];
    s_if.wvalid    = in[7];
    s_if.rready    = in[6];
    s_if.bready    = in[5];
    m_if.arready   = in[4];
    m_if.awready   = in[3];
    m_if.wready    = in[2];
    m_if.rvalid    = in[1];
    m_if.bvalid    = in[0];
  endtask

  function automatic logic [9:0] sample();
    return {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready,
            s_if.arready, s_if.awready, s_if.wready, s_if.rvalid, s_if.bvalid};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    s_if.awaddr = 32'h0060_0000;
    s_if.awprot = 3'b000;
    s_if.wdata  = 32'h0000_1234;
    s_if.wstrb  = 4'hF;
    s_if.araddr = 32'h0010_0004;
    s_if.arprot = 3'b000;
    m_if.rdata  = 32'hDEAD_BEEF;
    m_if.rresp  = axil_resp_okay_gp;
    m_if.bresp  = axil_resp_okay_gp;
    drive(1'b0, '0);

    // reset
    add(0, 10'b00000_00000, 10'b00000_00000);
    // single read
    add(1, 10'b10000_00000, 10'b00000_00000);
    add(1, 10'b10000_10000, 10'b10000_10000);
    add(1, 10'b00010_00010, 10'b00010_00010);
    add(1, 10'b00000_00000, 10'b00000_00000);
    // write with W two cycles ahead of AW; stray bvalid afterwards is not forwarded
    add(1, 10'b00100_00000, 10'b00000_00000);
    add(1, 10'b00100_00000, 10'b00000_00000);
    add(1, 10'b01100_00000, 10'b00000_00000);
    add(1, 10'b01100_01100, 10'b01100_01100);
    add(1, 10'b00001_00001, 10'b00001_00001);
    add(1, 10'b00001_00001, 10'b00000_00000);
    // contention: read, write, read, write
    add(1, 10'b11100_00000, 10'b00000_00000);
    add(1, 10'b11100_11100, 10'b10000_10000);
    add(1, 10'b01110_01010, 10'b00010_00010);
    add(1, 10'b11100_00000, 10'b00000_00000);
    add(1, 10'b11100_11100, 10'b01100_01100);
    add(1, 10'b10001_00001, 10'b00001_00001);
    add(1, 10'b11100_00000, 10'b00000_00000);
    add(1, 10'b11100_10000, 10'b10000_10000);
    add(1, 10'b01110_00010, 10'b00010_00010);
    add(1, 10'b11100_00000, 10'b00000_00000);
    // AW backpressure 5 cycles, W accepted first
    add(1, 10'b11100_00100, 10'b01100_00100);
    add(1, 10'b11000_00100, 10'b01000_00000);
    add(1, 10'b11000_00100, 10'b01000_00000);
    add(1, 10'b11000_00100, 10'b01000_00000);
    add(1, 10'b11000_00100, 10'b01000_00000);
    add(1, 10'b11000_01000, 10'b01000_01000);
    add(1, 10'b10001_00001, 10'b00001_00001);
    // response stall: rvalid held, s00 rready low 3 cycles, write waiting
    add(1, 10'b10000_00000, 10'b00000_00000);
    add(1, 10'b10000_10000, 10'b10000_10000);
    add(1, 10'b01100_01010, 10'b00000_00010);
    add(1, 10'b01100_01010, 10'b00000_00010);
    add(1, 10'b01100_01010, 10'b00000_00010);
    add(1, 10'b01110_01010, 10'b00010_00010);
    add(1, 10'b01100_00000, 10'b00000_00000);
    // reset mid-write after AW handshake
    add(1, 10'b01100_01000, 10'b01100_01000);
    add(0, 10'b00100_00000, 10'b00000_00000);
    add(1, 10'b00100_00000, 10'b00000_00000);
    // contention after reset goes to read; then write shows aw_done cleared
    add(1, 10'b11100_00000, 10'b00000_00000);
    add(1, 10'b11100_11000, 10'b10000_10000);
    add(1, 10'b01110_00010, 10'b00010_00010);
    add(1, 10'b01100_00000, 10'b00000_00000);
    add(1, 10'b01100_00100, 10'b01100_00100);
    add(1, 10'b01000_01000, 10'b01000_01000);
    add(1, 10'b00001_00001, 10'b00001_00001);
    add(1, 10'b00000_00000, 10'b00000_00000);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].in);
      #2;
      check($sformatf("row%0d_handshakes", i), 64'(sample()), 64'(tbl[i].exp));
      check($sformatf("row%0d_ar_aw_mutex", i), 64'(m_if.arvalid & m_if.awvalid), 64'd0);
      if (i == 2)
        check("read_addr_passthru", 64'(m_if.araddr), 64'h0010_0004);
      if (i == 3)
        check("read_data_resp", 64'({s_if.rdata, s_if.rresp}), 64'({32'hDEAD_BEEF, 2'b00}));
      if (i == 8)
        check("write_addr_data", 64'({m_if.awaddr, m_if.wdata}), {32'h0060_0000, 32'h0000_1234});
      if (i == 9)
        check("write_bresp", 64'(s_if.bresp), 64'd0);
    end

    // payload passthrough with non-default values
    @(negedge clk);
    s_if.araddr = 32'hA5A5_0008;
    s_if.arprot = 3'b101;
    s_if.awprot = 3'b011;
    s_if.wstrb  = 4'b0011;
    m_if.bresp  = axil_resp_slverr_gp;
    m_if.rresp  = axil_resp_slverr_gp;
    m_if.rdata  = 32'h0BAD_F00D;
    #2;
    check("araddr_arprot", 64'({m_if.araddr, m_if.arprot}), 64'({32'hA5A5_0008, 3'b101}));
    check("awprot_wstrb", 64'({m_if.awprot, m_if.wstrb}), 64'({3'b011, 4'b0011}));
    check("resp_slverr", 64'({s_if.bresp, s_if.rresp}), 64'({2'b10, 2'b10}));
    check("rdata_passthru", 64'(s_if.rdata), 64'h0BAD_F00D);
    check("idle_quiet", 64'(sample()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
